sm_minmax_scheduler: RTL and testbench

Frame-based min/max tracker for N-bit sign-magnitude samples. It accepts a frame of L samples over a valid/ready handshake and time-shares a single `comparator` instance (A ≥ B, sign-magnitude) between the max and min updates. After the last sample it reports the frame maximum and minimum with a one-cycle done pulse. It sits downstream of the sample source and upstream of any consumer of frame extrema.

---
 rtl/sm_cmp_pkg.sv | 27 ++
 rtl/comparator.sv | 39 +++
 rtl/sm_minmax_scheduler.sv | 130 +++++++++++++
 tb/tb_sm_minmax_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm_cmp_pkg.sv
// ---------------------------------------------------------------------------
// sm_cmp_pkg
// Shared types and constants for the sign-magnitude min/max scheduler.
//   state_t            scheduler FSM states
//   SM_N               default sample width
//   SIGN_IDX/MAG_MSB   sign bit and magnitude MSB positions for SM_N
//   POS_ZERO/NEG_ZERO  the two encodings of zero
// ---------------------------------------------------------------------------
package sm_cmp_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FIRST   = 3'd1,
        WAIT    = 3'd2,
        CMP_MAX = 3'd3,
        CMP_MIN = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int SM_N     = 8;
    localparam int SIGN_IDX = SM_N - 1;
    localparam int MAG_MSB  = SM_N - 2;

    localparam logic [SM_N-1:0] POS_ZERO = {SM_N{1'b0}};
    localparam logic [SM_N-1:0] NEG_ZERO = {1'b1, {(SM_N-1){1'b0}}};

endpackage

// File: rtl/comparator.sv
// ---------------------------------------------------------------------------
// comparator
// Combinational sign-magnitude compare, o_ge = (i_a >= i_b) numerically.
//   i_a, i_b  N-bit sign-magnitude operands (bit N-1 = sign, 1 = negative)
//   o_ge      1 when i_a >= i_b
// ---------------------------------------------------------------------------
module comparator #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_ge
);

    logic [N-2:0] w_mag_a;
    logic [N-2:0] w_mag_b;
    logic         w_neg_a;
    logic         w_neg_b;

    assign w_mag_a = i_a[N-2:0];
    assign w_mag_b = i_b[N-2:0];

    // -0 is folded onto +0 so both zero encodings compare equal.
    assign w_neg_a = i_a[N-1] && (w_mag_a != '0);
    assign w_neg_b = i_b[N-1] && (w_mag_b != '0);

    always_comb begin
        o_ge = 1'b0;
        if (w_neg_a != w_neg_b) begin
            o_ge = w_neg_b;
        end else if (w_neg_a) begin
            // among negatives the larger magnitude is the smaller value
            o_ge = (w_mag_a <= w_mag_b);
        end else begin
            o_ge = (w_mag_a >= w_mag_b);
        end
    end

endmodule

// File: rtl/sm_minmax_scheduler.sv
// ---------------------------------------------------------------------------
// sm_minmax_scheduler
// Tracks max and min of a frame of L sign-magnitude samples, sharing one
// comparator between the max and min updates.
//   i_clk, i_rst_n      clock, async active-low reset
//   i_start             start a frame (only honoured in IDLE)
//   i_data, i_valid     sample stream; transfer on i_valid && o_ready
//   o_ready             block accepts a sample this cycle
//   o_busy              not in IDLE
//   o_done              one-cycle pulse, o_max/o_min final
//   o_max, o_min        frame extrema (held until next frame's first sample)
//   o_count             samples accepted in the current frame
//
// state   | meaning
// IDLE    | waiting for i_start
// FIRST   | accept first sample, seeds max and min
// WAIT    | accept next sample into r_sample
// CMP_MAX | comparator = (max >= sample); replace max if not
// CMP_MIN | comparator = (sample >= min); replace min if not; count++
// DONE    | o_done pulse, back to IDLE
// ---------------------------------------------------------------------------
module sm_minmax_scheduler
    import sm_cmp_pkg::*;
#(
    parameter int N = SM_N,
    parameter int L = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [N-1:0]           i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [N-1:0]           o_max,
    output logic [N-1:0]           o_min,
    output logic [$clog2(L+1)-1:0] o_count
);

    localparam int            CW    = $clog2(L + 1);
    localparam logic [CW-1:0] L_CNT = CW'(L);

    state_t        r_state;
    logic [N-1:0]  r_max;
    logic [N-1:0]  r_min;
    logic [N-1:0]  r_sample;
    logic [CW-1:0] r_count;

    logic [N-1:0]  w_cmp_a;
    logic [N-1:0]  w_cmp_b;
    logic          w_ge;
    logic          w_xfer;
    logic [CW-1:0] w_count_inc;

    assign w_xfer      = i_valid && o_ready;
    assign w_count_inc = r_count + 1'b1;

    // Operand order swaps in CMP_MIN so "not ge" always means "replace".
    always_comb begin
        w_cmp_a = r_max;
        w_cmp_b = r_sample;
        if (r_state == CMP_MIN) begin
            w_cmp_a = r_sample;
            w_cmp_b = r_min;
        end
    end

    comparator #(.N(N)) u_cmp (
        .i_a  (w_cmp_a),
        .i_b  (w_cmp_b),
        .o_ge (w_ge)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_max    <= '0;
            r_min    <= '0;
            r_sample <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_count <= '0;
                        r_state <= FIRST;
                    end
                end
                FIRST: begin
                    if (w_xfer) begin
                        r_max   <= i_data;
                        r_min   <= i_data;
                        r_count <= CW'(1);
                        r_state <= (L == 1) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (w_xfer) begin
                        r_sample <= i_data;
                        r_state  <= CMP_MAX;
                    end
                end
                CMP_MAX: begin
                    if (!w_ge) r_max <= r_sample;
                    r_state <= CMP_MIN;
                end
                CMP_MIN: begin
                    if (!w_ge) r_min <= r_sample;
                    r_count <= w_count_inc;
                    r_state <= (w_count_inc == L_CNT) ? DONE : WAIT;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_ready = (r_state == FIRST) || (r_state == WAIT);
    assign o_busy  = (r_state != IDLE);
    assign o_done  = (r_state == DONE);
    assign o_max   = r_max;
    assign o_min   = r_min;
    assign o_count = r_count;

endmodule

// File: tb/tb_sm_minmax_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sm_minmax_scheduler
// Directed bench: four scheduler instances (L = 4, 3, 2, 1) share clock,
// reset and data; only the selected instance ever sees i_start.
// ---------------------------------------------------------------------------
module tb_sm_minmax_scheduler;

    localparam int NI = 4;
    localparam int LS [NI] = '{4, 3, 2, 1};

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] i_data;
    logic       i_valid;
    int         sel;

    logic       rdy_a  [NI];
    logic       busy_a [NI];
    logic       done_a [NI];
    logic [7:0] max_a  [NI];
    logic [7:0] min_a  [NI];
    logic [2:0] cnt_a  [NI];

    logic       w_ready, w_busy, w_done;
    logic [7:0] w_max, w_min;
    logic [2:0] w_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] vec [16];
    logic [7:0] cap_max, cap_min;
    logic [2:0] cap_cnt;
    logic       cap_ready, cap_busy;
    int         lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            localparam int LG = LS[g];
            logic [$clog2(LG+1)-1:0] cnt;
            sm_minmax_scheduler #(.N(8), .L(LG)) u_dut (
                .i_clk   (clk),
                .i_rst_n (rst_n),
                .i_start (start && (sel == g)),
                .i_data  (i_data),
                .i_valid (i_valid),
                .o_ready (rdy_a[g]),
                .o_busy  (busy_a[g]),
                .o_done  (done_a[g]),
                .o_max   (max_a[g]),
                .o_min   (min_a[g]),
                .o_count (cnt)
            );
            assign cnt_a[g] = 3'(cnt);
        end
    endgenerate

    always_comb begin
        w_ready = rdy_a[sel];
        w_busy  = busy_a[sel];
        w_done  = done_a[sel];
        w_max   = max_a[sel];
        w_min   = min_a[sel];
        w_cnt   = cnt_a[sel];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: valid held; 1: valid held, junk data while not ready;
    // 2: random valid gaps. lat = edges from the edge that launches i_start
    // up to and including the edge after which o_done is seen.
    task automatic run_frame(input int s, input int n, input int mode,
                             input int pulse_at, output int lat_o);
        int   idx;
        logic xfer;
        bit   seen;
        idx   = 0;
        seen  = 0;
        lat_o = 0;
        sel   = s;
        @(posedge clk); #1;
        start   = 1'b1;
        i_data  = vec[0];
        i_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 1; c <= 300 && !seen; c++) begin
            @(negedge clk);
            xfer = w_ready && i_valid;
            @(posedge clk); #1;
            start = (c == pulse_at);
            if (xfer) idx++;
            if (w_done) begin
                seen      = 1;
                lat_o     = c;
                cap_max   = w_max;
                cap_min   = w_min;
                cap_cnt   = w_cnt;
                cap_ready = w_ready;
                cap_busy  = w_busy;
            end
            if (idx >= n) begin
                i_valid = 1'b0;
            end else begin
                i_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                i_data  = (w_ready || mode != 1) ? vec[idx] : 8'($urandom_range(0, 255));
            end
        end
        start   = 1'b0;
        i_valid = 1'b0;
        check_val("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        i_data  = 8'h00;
        i_valid = 1'b0;
        sel     = 0;
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_ready", 32'(w_ready), 32'd0);
        check_val("rst_busy",  32'(w_busy),  32'd0);
        check_val("rst_done",  32'(w_done),  32'd0);
        check_val("rst_max",   32'(w_max),   32'h00);
        check_val("rst_min",   32'(w_min),   32'h00);
        check_val("rst_count", 32'(w_cnt),   32'd0);
        #10 rst_n = 1'b1;

        // mixed signs, L=4
        vec[0] = 8'h05; vec[1] = 8'h83; vec[2] = 8'h7F; vec[3] = 8'hFF;
        run_frame(0, 4, 0, 0, lat);
        check_val("mix_max",   32'(cap_max),   32'h7F);
        check_val("mix_min",   32'(cap_min),   32'hFF);
        check_val("mix_cnt",   32'(cap_cnt),   32'd4);
        check_val("mix_lat",   32'(lat),       32'd11);
        check_val("mix_rdy",   32'(cap_ready), 32'd0);
        check_val("mix_busy",  32'(cap_busy),  32'd1);
        @(posedge clk); #1;
        check_val("post_done", 32'(w_done), 32'd0);
        check_val("post_busy", 32'(w_busy), 32'd0);
        check_val("hold_max",  32'(w_max),  32'h7F);
        check_val("hold_min",  32'(w_min),  32'hFF);

        // all negatives, L=3
        vec[0] = 8'h85; vec[1] = 8'h82; vec[2] = 8'h89;
        run_frame(1, 3, 0, 0, lat);
        check_val("neg_max", 32'(cap_max), 32'h82);
        check_val("neg_min", 32'(cap_min), 32'h89);
        check_val("neg_lat", 32'(lat),     32'd8);

        // signed zero ties keep the earlier sample, L=2
        vec[0] = 8'h80; vec[1] = 8'h00;
        run_frame(2, 2, 0, 0, lat);
        check_val("z1_max", 32'(cap_max), 32'h80);
        check_val("z1_min", 32'(cap_min), 32'h80);
        check_val("z1_lat", 32'(lat),     32'd5);
        vec[0] = 8'h00; vec[1] = 8'h80;
        run_frame(2, 2, 0, 0, lat);
        check_val("z2_max", 32'(cap_max), 32'h00);
        check_val("z2_min", 32'(cap_min), 32'h00);

        // junk data while not ready must be ignored
        vec[0] = 8'h05; vec[1] = 8'h83; vec[2] = 8'h7F; vec[3] = 8'hFF;
        run_frame(0, 4, 1, 0, lat);
        check_val("bp_max", 32'(cap_max), 32'h7F);
        check_val("bp_min", 32'(cap_min), 32'hFF);
        check_val("bp_lat", 32'(lat),     32'd11);

        // random valid gaps
        for (int r = 0; r < 3; r++) begin
            run_frame(0, 4, 2, 0, lat);
            check_val("gap_max", 32'(cap_max), 32'h7F);
            check_val("gap_min", 32'(cap_min), 32'hFF);
            check_val("gap_cnt", 32'(cap_cnt), 32'd4);
        end

        // start pulse mid-frame is ignored
        vec[0] = 8'h12; vec[1] = 8'h9F; vec[2] = 8'h34; vec[3] = 8'h81;
        run_frame(0, 4, 0, 5, lat);
        check_val("sp_max", 32'(cap_max), 32'h34);
        check_val("sp_min", 32'(cap_min), 32'h9F);
        check_val("sp_lat", 32'(lat),     32'd11);

        // single-sample frame, L=1
        vec[0] = 8'h9A;
        run_frame(3, 1, 0, 0, lat);
        check_val("l1_max", 32'(cap_max), 32'h9A);
        check_val("l1_min", 32'(cap_min), 32'h9A);
        check_val("l1_cnt", 32'(cap_cnt), 32'd1);
        check_val("l1_lat", 32'(lat),     32'd2);

        // reset during CMP_MIN of the second sample
        sel = 0;
        vec[0] = 8'h05; vec[1] = 8'h83;
        @(posedge clk); #1;
        start = 1'b1; i_valid = 1'b1; i_data = vec[0];
        @(posedge clk); #1;            // FIRST
        start = 1'b0;
        @(posedge clk); #1;            // WAIT
        i_data = vec[1];
        @(posedge clk); #1;            // CMP_MAX
        i_valid = 1'b0;
        @(posedge clk); #1;            // CMP_MIN
        check_val("ab_busy_pre",  32'(w_busy),  32'd1);
        check_val("ab_ready_pre", 32'(w_ready), 32'd0);
        check_val("ab_cnt_pre",   32'(w_cnt),   32'd1);
        rst_n = 1'b0;
        #1;
        check_val("ab_busy",  32'(w_busy),  32'd0);
        check_val("ab_ready", 32'(w_ready), 32'd0);
        check_val("ab_done",  32'(w_done),  32'd0);
        check_val("ab_max",   32'(w_max),   32'h00);
        check_val("ab_min",   32'(w_min),   32'h00);
        check_val("ab_cnt",   32'(w_cnt),   32'd0);
        #2 rst_n = 1'b1;

        vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h93; vec[3] = 8'h84;
        run_frame(0, 4, 0, 0, lat);
        check_val("rec_max", 32'(cap_max), 32'h22);
        check_val("rec_min", 32'(cap_min), 32'h93);
        check_val("rec_cnt", 32'(cap_cnt), 32'd4);
        check_val("rec_lat", 32'(lat),     32'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
